// File: rtl/multi_interval_timer.sv
// multi_interval_timer: NCHAN prescaled down-counting channels behind one OCP slave, W1C status, one IRQ.
// Optional feature macro TIMER_CHAIN_EN: channel c may tick on each expiry of channel c-1.
module multi_interval_timer #(
  parameter int unsigned NCHAN       = 4,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned PRESC_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  localparam int unsigned BEN_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_MAddr,
  input  logic [2:0]            i_MCmd,
  input  logic [DATA_WIDTH-1:0] i_MData,
  input  logic [BEN_WIDTH-1:0]  i_MByteEn,
  output logic                  o_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_SData,
  output logic [1:0]            o_SResp,
  output logic                  o_intr
);
  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_WRITE = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;
  localparam int unsigned ISR_ADDR  = 'h100;
  localparam int unsigned SEL_WIDTH = 3;

  logic [NCHAN-1:0]       en_q, rld_q, imask_q, chain_q, pend_q;
  logic [PRESC_WIDTH-1:0] presc_q [NCHAN];
  logic [PRESC_WIDTH-1:0] pcnt_q  [NCHAN];
  logic [CNT_WIDTH-1:0]   cntr_q  [NCHAN];
  logic [CNT_WIDTH-1:0]   curr_q  [NCHAN];

  logic                   wr_hit, rd_hit, is_isr, is_chan, hit, src;
  logic [SEL_WIDTH-1:0]   sel;
  logic [3:0]             off;
  logic [DATA_WIDTH-1:0]  rdata, wdata;
  logic [NCHAN-1:0]       tick, expire, ctrl_wr, cntr_wr, clr;

`ifdef TIMER_CHAIN_EN
  logic                   prev_exp;
`else
  assign chain_q = '0;
`endif

  assign o_SCmdAccept = (i_MCmd != CMD_IDLE);
  assign o_intr       = |(pend_q & imask_q);

  // Address decode: channel registers at 0x10*c (+0/+4/+8), ISR at 0x100
  always_comb begin
    wr_hit  = (i_MCmd == CMD_WRITE);
    rd_hit  = (i_MCmd == CMD_READ);
    sel     = i_MAddr[6:4];
    off     = i_MAddr[3:0];
    is_isr  = (i_MAddr == ADDR_WIDTH'(ISR_ADDR));
    is_chan = (i_MAddr[ADDR_WIDTH-1:4] < (ADDR_WIDTH-4)'(NCHAN)) &&
              ((off == 4'h0) || (off == 4'h4) || (off == 4'h8));
    hit     = is_isr || is_chan;
    clr     = (wr_hit && is_isr && i_MByteEn[0]) ? i_MData[NCHAN-1:0] : '0;
  end

  // Read mux; also the base for byte-lane merged writes
  always_comb begin
    rdata = '0;
    if (is_isr) rdata = DATA_WIDTH'(pend_q);
    for (int c = 0; c < int'(NCHAN); c++) begin
      if (is_chan && (sel == SEL_WIDTH'(c))) begin
        case (off)
          4'h0:    rdata = DATA_WIDTH'({presc_q[c], 4'b0000, chain_q[c], imask_q[c], rld_q[c], en_q[c]});
          4'h4:    rdata = DATA_WIDTH'(cntr_q[c]);
          4'h8:    rdata = DATA_WIDTH'(curr_q[c]);
          default: rdata = '0;
        endcase
      end
    end
  end

  always_comb begin
    wdata = rdata;
    for (int b = 0; b < int'(BEN_WIDTH); b++) begin
      if (i_MByteEn[b]) wdata[8*b +: 8] = i_MData[8*b +: 8];
    end
  end

  // Tick sources; a CTRL write to a channel discards that channel's tick
  always_comb begin
    tick    = '0;
    expire  = '0;
    ctrl_wr = '0;
    cntr_wr = '0;
    src     = 1'b0;
`ifdef TIMER_CHAIN_EN
    prev_exp = 1'b0;
`endif
    for (int c = 0; c < int'(NCHAN); c++) begin
      ctrl_wr[c] = wr_hit && is_chan && (sel == SEL_WIDTH'(c)) && (off == 4'h0);
      cntr_wr[c] = wr_hit && is_chan && (sel == SEL_WIDTH'(c)) && (off == 4'h4);
      src        = (pcnt_q[c] == presc_q[c]);
`ifdef TIMER_CHAIN_EN
      if (chain_q[c]) src = prev_exp;
`endif
      tick[c]    = en_q[c] && src && !ctrl_wr[c];
      expire[c]  = tick[c] && (curr_q[c] == CNT_WIDTH'(1));
`ifdef TIMER_CHAIN_EN
      prev_exp   = expire[c];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= '0;
      rld_q   <= '0;
      imask_q <= '0;
      pend_q  <= '0;
`ifdef TIMER_CHAIN_EN
      chain_q <= '0;
`endif
      for (int c = 0; c < int'(NCHAN); c++) begin
        presc_q[c] <= '0;
        pcnt_q[c]  <= '0;
        cntr_q[c]  <= '0;
        curr_q[c]  <= '0;
      end
      o_SResp <= RESP_NULL;
      o_SData <= '0;
    end else begin
      o_SResp <= RESP_NULL;
      o_SData <= '0;
      if (wr_hit || rd_hit) o_SResp <= hit ? RESP_DVA : RESP_ERR;
      else if (i_MCmd != CMD_IDLE) o_SResp <= RESP_ERR;
      if (rd_hit && hit) o_SData <= rdata;

      for (int c = 0; c < int'(NCHAN); c++) begin
        // Expiry set dominates a simultaneous W1C
        pend_q[c] <= (pend_q[c] && !clr[c]) || expire[c];
        if (ctrl_wr[c]) begin
          rld_q[c]   <= wdata[1];
          imask_q[c] <= wdata[2];
          presc_q[c] <= wdata[8 +: PRESC_WIDTH];
          pcnt_q[c]  <= '0;
`ifdef TIMER_CHAIN_EN
          chain_q[c] <= (c != 0) && wdata[3];
`endif
          if (wdata[0]) begin
            curr_q[c] <= cntr_q[c];
            en_q[c]   <= (cntr_q[c] != '0);
          end else begin
            en_q[c]   <= 1'b0;
          end
        end else if (en_q[c]) begin
          pcnt_q[c] <= (pcnt_q[c] == presc_q[c]) ? '0 : pcnt_q[c] + PRESC_WIDTH'(1);
          if (tick[c]) begin
            if (expire[c]) begin
              if (rld_q[c]) begin
                curr_q[c] <= cntr_q[c];
              end else begin
                curr_q[c] <= '0;
                en_q[c]   <= 1'b0;
              end
            end else begin
              curr_q[c] <= curr_q[c] - CNT_WIDTH'(1);
            end
          end
        end else begin
          pcnt_q[c] <= '0;
        end
        if (cntr_wr[c]) cntr_q[c] <= wdata[CNT_WIDTH-1:0];
      end
    end
  end

endmodule
